// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline branch logic: branch type
// codes, 2-bit predictor counter states and the taken/saturation rules.
package mips_pkg;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLEZ = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BLTZ = 3'b100,
        BR_BGEZ = 3'b101,
        BR_J    = 3'b110,
        BR_RSVD = 3'b111
    } br_type_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int PERF_W = 32;

    function automatic logic br_taken(input br_type_e br_type, input logic zero, input logic neg);
        logic taken;
        taken = 1'b0;
        case (br_type)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLEZ: taken = neg | zero;
            BR_BGTZ: taken = !neg & !zero;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = !neg;
            BR_J:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    // Only the six compare-based types train the predictor.
    function automatic logic br_is_cond(input br_type_e br_type);
        return (br_type != BR_J) && (br_type != BR_RSVD);
    endfunction

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] next_cnt;
        next_cnt = cnt;
        if (taken) begin
            if (cnt != ST) next_cnt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) next_cnt = cnt - 2'd1;
        end
        return next_cnt;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Bundle of ID-stage prediction, EX-stage resolution and perf signals
// exchanged between the pipeline and the branch resolve unit.
interface branch_resolve_unit_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] id_pc;
    logic              id_branch;
    logic              id_pred_taken;

    logic              ex_valid;
    logic              ex_branch;
    br_type_e          ex_br_type;
    logic              ex_zero;
    logic              ex_neg;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_target;
    logic              ex_pred_taken;

    logic              pc_src;
    logic              flush;
    logic [DATA_W-1:0] redirect_pc;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    modport master (
        output id_pc, id_branch,
        output ex_valid, ex_branch, ex_br_type, ex_zero, ex_neg, ex_pc, ex_target, ex_pred_taken,
        input  id_pred_taken, pc_src, flush, redirect_pc, perf_branches, perf_mispredicts
    );

    modport slave (
        input  id_pc, id_branch,
        input  ex_valid, ex_branch, ex_br_type, ex_zero, ex_neg, ex_pc, ex_target, ex_pred_taken,
        output id_pred_taken, pc_src, flush, redirect_pc, perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/branch_resolve_unit_bht.sv
// Branch history table of 2-bit saturating counters: asynchronous read of the
// direction bit, synchronous saturating update, synchronous reset to CNT_INIT.
module bht_table
    import mips_pkg::*;
#(
    parameter int         BHT_IDX_W = 6,
    parameter logic [1:0] CNT_INIT  = WNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic                 rd_pred,
    input  logic                 wr_en,
    input  logic [BHT_IDX_W-1:0] wr_idx,
    input  logic                 wr_taken
);
    localparam int DEPTH = 1 << BHT_IDX_W;

    logic [1:0] cnt_reg [DEPTH];
    logic [1:0] cnt_next;

    // Read sees the stored value, so a same-cycle write is not forwarded.
    assign rd_pred  = cnt_reg[rd_idx][1];
    assign cnt_next = sat_update(cnt_reg[wr_idx], wr_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_reg[i] <= CNT_INIT;
            end
        end else if (wr_en) begin
            cnt_reg[wr_idx] <= cnt_next;
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch decision block: resolves branches/jumps in EX, predicts in ID from the
// BHT, raises flush with a corrected PC on mispredict and counts events.
module branch_resolve_unit
    import mips_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter int         BHT_IDX_W  = 6,
    parameter logic [1:0] CNT_INIT   = WNT,
    parameter bit         PREDICT_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    branch_resolve_unit_if.slave bus
);
    logic                 taken;
    logic                 resolve;
    logic                 update_elig;
    logic                 mispredict;
    logic                 bht_pred;
    logic [DATA_W-1:0]    seq_pc;
    logic [PERF_W-1:0]    perf_br_reg;
    logic [PERF_W-1:0]    perf_mis_reg;

    assign taken       = br_taken(bus.ex_br_type, bus.ex_zero, bus.ex_neg);
    // Reset masks resolution so nothing in flight can flush or train.
    assign resolve     = bus.ex_valid & bus.ex_branch & !rst;
    assign update_elig = resolve & br_is_cond(bus.ex_br_type);
    assign mispredict  = resolve & (taken != bus.ex_pred_taken);
    assign seq_pc      = bus.ex_pc + DATA_W'(4);

    assign bus.pc_src  = resolve & taken;
    assign bus.flush   = mispredict;

    always_comb begin
        bus.redirect_pc = seq_pc;
        if (rst) begin
            bus.redirect_pc = '0;
        end else if (mispredict && taken) begin
            bus.redirect_pc = bus.ex_target;
        end
    end

    bht_table #(
        .BHT_IDX_W (BHT_IDX_W),
        .CNT_INIT  (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.id_pc[BHT_IDX_W+1:2]),
        .rd_pred  (bht_pred),
        .wr_en    (PREDICT_EN & update_elig),
        .wr_idx   (bus.ex_pc[BHT_IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign bus.id_pred_taken = PREDICT_EN & !rst & bus.id_branch & bht_pred;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_br_reg  <= '0;
            perf_mis_reg <= '0;
        end else begin
            if (update_elig) perf_br_reg  <= perf_br_reg + PERF_W'(1);
            if (mispredict)  perf_mis_reg <= perf_mis_reg + PERF_W'(1);
        end
    end

    assign bus.perf_branches    = perf_br_reg;
    assign bus.perf_mispredicts = perf_mis_reg;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed EX/ID vectors push expected
// responses; a negedge monitor pops and compares a predicting and a static build.
module tb_branch_resolve_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DATA_W(32)) bus ();
    branch_resolve_unit_if #(.DATA_W(32)) bus0 ();

    branch_resolve_unit #(.DATA_W(32), .BHT_IDX_W(6), .CNT_INIT(2'b01), .PREDICT_EN(1'b1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    branch_resolve_unit #(.DATA_W(32), .BHT_IDX_W(6), .CNT_INIT(2'b01), .PREDICT_EN(1'b0))
        dut_static (.clk(clk), .rst(rst), .bus(bus0));

    assign bus0.id_pc         = bus.id_pc;
    assign bus0.id_branch     = bus.id_branch;
    assign bus0.ex_valid      = bus.ex_valid;
    assign bus0.ex_branch     = bus.ex_branch;
    assign bus0.ex_br_type    = bus.ex_br_type;
    assign bus0.ex_zero       = bus.ex_zero;
    assign bus0.ex_neg        = bus.ex_neg;
    assign bus0.ex_pc         = bus.ex_pc;
    assign bus0.ex_target     = bus.ex_target;
    assign bus0.ex_pred_taken = bus.ex_pred_taken;

    typedef struct {
        string       name;
        bit          pc_src;
        bit          flush;
        logic [31:0] redir;
        bit          chk_pred;
        bit          pred;
        bit          chk_perf;
        int          br;
        int          mis;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks = 0;
    int   failures = 0;

    // Taken mask per type, bit index = {zero,neg}.
    logic [3:0] taken_tbl [8] = '{4'b1100, 4'b0011, 4'b1110, 4'b0001,
                                  4'b1010, 4'b0101, 4'b1111, 4'b0000};

    task automatic chk(input string txn, input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%08h required=0x%08h", txn, what, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            int f0;
            f0 = failures;
            cur = q.pop_front();
            chk(cur.name, "pc_src",      32'(bus.pc_src),       32'(cur.pc_src));
            chk(cur.name, "flush",       32'(bus.flush),        32'(cur.flush));
            chk(cur.name, "redirect_pc", bus.redirect_pc,       cur.redir);
            chk(cur.name, "static_flush", 32'(bus0.flush),      32'(cur.flush));
            chk(cur.name, "static_redirect", bus0.redirect_pc,  cur.redir);
            if (cur.chk_pred) begin
                chk(cur.name, "id_pred_taken", 32'(bus.id_pred_taken), 32'(cur.pred));
                chk(cur.name, "static_pred",   32'(bus0.id_pred_taken), 32'd0);
            end
            if (cur.chk_perf) begin
                chk(cur.name, "perf_branches",    bus.perf_branches,    32'(cur.br));
                chk(cur.name, "perf_mispredicts", bus.perf_mispredicts, 32'(cur.mis));
            end
            $display("txn %-14s pc_src=%0b flush=%0b redirect=0x%08h pred=%0b br=%0d mis=%0d %s",
                     cur.name, bus.pc_src, bus.flush, bus.redirect_pc, bus.id_pred_taken,
                     bus.perf_branches, bus.perf_mispredicts, (failures == f0) ? "ok" : "bad");
        end
    end

    task automatic step(input bit r, input bit v, input bit b, input logic [2:0] ty,
                        input bit z, input bit n, input logic [31:0] pc, input logic [31:0] tg,
                        input bit pt, input logic [31:0] ipc, input bit ib);
        @(posedge clk);
        #1;
        rst               = r;
        bus.ex_valid      = v;
        bus.ex_branch     = b;
        bus.ex_br_type    = br_type_e'(ty);
        bus.ex_zero       = z;
        bus.ex_neg        = n;
        bus.ex_pc         = pc;
        bus.ex_target     = tg;
        bus.ex_pred_taken = pt;
        bus.id_pc         = ipc;
        bus.id_branch     = ib;
    endtask

    task automatic exp_full(input string nm, input bit pcs, input bit fl, input logic [31:0] rd,
                            input bit pr, input int br, input int mis);
        exp_t e;
        e.name = nm; e.pc_src = pcs; e.flush = fl; e.redir = rd;
        e.chk_pred = 1'b1; e.pred = pr; e.chk_perf = 1'b1; e.br = br; e.mis = mis;
        q.push_back(e);
    endtask

    task automatic exp_ex(input string nm, input bit pcs, input bit fl, input logic [31:0] rd);
        exp_t e;
        e.name = nm; e.pc_src = pcs; e.flush = fl; e.redir = rd;
        e.chk_pred = 1'b0; e.pred = 1'b0; e.chk_perf = 1'b0; e.br = 0; e.mis = 0;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_br_type = BR_BEQ; bus.ex_zero = 0;
        bus.ex_neg = 0; bus.ex_pc = 0; bus.ex_target = 0; bus.ex_pred_taken = 0;
        bus.id_pc = 0; bus.id_branch = 0;

        // Reset forcing and first mispredicted BEQ
        step(1, 1, 1, 3'd0, 1, 0, 32'h100, 32'h140, 0, 32'h100, 1); exp_full("reset_hold", 0, 0, 32'h0,   0, 0, 0);
        step(0, 1, 1, 3'd0, 1, 0, 32'h100, 32'h140, 0, 32'h100, 1); exp_full("beq_mispred", 1, 1, 32'h140, 0, 0, 0);
        step(0, 0, 1, 3'd0, 1, 0, 32'h100, 32'h140, 0, 32'h100, 1); exp_full("beq_learn",  0, 0, 32'h104, 1, 1, 1);
        step(1, 0, 0, 3'd0, 0, 0, 32'h100, 32'h140, 0, 32'h100, 1); exp_full("reset2",     0, 0, 32'h0,   0, 1, 1);
        step(0, 0, 0, 3'd0, 0, 0, 32'h100, 32'h140, 0, 32'h100, 1); exp_full("post_reset", 0, 0, 32'h104, 0, 0, 0);

        // Loop training at 0x200: 01->10->11->11->11, then down to 10, 01
        step(0, 1, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop1", 1, 0, 32'h204, 0, 0, 0);
        step(0, 1, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop2", 1, 0, 32'h204, 1, 1, 0);
        step(0, 1, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop3", 1, 0, 32'h204, 1, 2, 0);
        step(0, 1, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop4", 1, 0, 32'h204, 1, 3, 0);
        step(0, 1, 1, 3'd0, 0, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop_exit", 0, 1, 32'h204, 1, 4, 0);
        step(0, 0, 1, 3'd0, 0, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop_idle", 0, 0, 32'h204, 1, 5, 1);
        step(0, 1, 1, 3'd0, 0, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop_exit2", 0, 1, 32'h204, 1, 5, 1);
        step(0, 0, 1, 3'd0, 0, 0, 32'h200, 32'h1C0, 1, 32'h200, 1); exp_full("loop_idle2", 0, 0, 32'h204, 0, 6, 2);

        // Stall: ex_valid low for three cycles, then one real resolution
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 0, 32'h200, 1);
            exp_full($sformatf("stall%0d", i), 0, 0, 32'h204, 0, 6, 2);
        end
        step(0, 1, 1, 3'd0, 1, 0, 32'h200, 32'h1C0, 0, 32'h200, 1); exp_full("stall_release", 1, 1, 32'h1C0, 0, 6, 2);
        step(0, 0, 1, 3'd0, 0, 0, 32'h200, 32'h1C0, 0, 32'h200, 1); exp_full("stall_after", 0, 0, 32'h204, 1, 7, 3);

        step(1, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h0, 0); exp_full("reset3", 0, 0, 32'h0, 0, 7, 3);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h0, 0); exp_full("post_reset3", 0, 0, 32'h304, 0, 0, 0);

        // Type x {zero,neg} sweep, predicted not-taken so flush follows taken
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 4; c++) begin
                logic [2:0] ty;
                logic [1:0] zn;
                bit tk;
                ty = t[2:0];
                zn = c[1:0];
                tk = taken_tbl[t][c];
                step(0, 1, 1, ty, zn[1], zn[0], 32'h300, 32'h3A0, 0, 32'h0, 0);
                exp_ex($sformatf("sweep_t%0d_c%0d", t, c), tk, tk, tk ? 32'h3A0 : 32'h304);
            end
        end
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h0, 0); exp_full("sweep_perf", 0, 0, 32'h304, 0, 24, 16);

        // Redirect wraps modulo 2^32
        step(0, 1, 1, 3'd0, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h0, 0); exp_ex("wrap", 0, 1, 32'h0);
        step(1, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h0, 0); exp_full("reset4", 0, 0, 32'h0, 0, 25, 17);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("post_reset4", 0, 0, 32'h304, 0, 0, 0);

        // J and reserved never train the BHT
        step(0, 1, 1, 3'd6, 0, 0, 32'h300, 32'h3A0, 1, 32'h300, 1); exp_full("jump", 1, 0, 32'h304, 0, 0, 0);
        step(0, 1, 1, 3'd7, 1, 1, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("rsvd1", 0, 0, 32'h304, 0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("no_train", 0, 0, 32'h304, 0, 0, 0);
        step(0, 1, 1, 3'd0, 1, 0, 32'h300, 32'h3A0, 1, 32'h300, 1); exp_full("beq_train", 1, 0, 32'h304, 0, 0, 0);
        step(0, 1, 1, 3'd7, 0, 0, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("rsvd2", 0, 0, 32'h304, 1, 1, 0);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("rsvd_hold", 0, 0, 32'h304, 1, 1, 0);

        // Reset in the cycle of a mispredict
        step(1, 1, 1, 3'd0, 0, 0, 32'h300, 32'h3A0, 1, 32'h300, 1); exp_full("rst_mispred", 0, 0, 32'h0, 0, 1, 0);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h300, 1); exp_full("rst_idx0", 0, 0, 32'h304, 0, 0, 0);
        step(0, 0, 0, 3'd0, 0, 0, 32'h300, 32'h3A0, 0, 32'h0FC, 1); exp_full("rst_idx63", 0, 0, 32'h304, 0, 0, 0);

        // Taken BNE at 0x300; static build must flush identically and never predict
        step(0, 1, 1, 3'd1, 0, 0, 32'h300, 32'h380, 0, 32'h300, 1); exp_full("bne_taken", 1, 1, 32'h380, 0, 0, 0);
        step(0, 0, 0, 3'd1, 0, 0, 32'h300, 32'h380, 0, 32'h300, 1); exp_full("bne_after", 0, 0, 32'h304, 1, 1, 1);

        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
